// File: rtl/nvme_rst_pkg.sv
// Purpose : shared encodings and defaults for the NVMe user-reset request block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: one-hot FSM state encodings, the NSSR magic word ("NVMe") and the
// default timing parameters used by nvme_user_rst_req.
package nvme_rst_pkg;

  // One-hot state encoding for the reset request sequencer.
  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_REQ      = 5'b00010,
    S_WAIT_ACK = 5'b00100,
    S_WAIT_REL = 5'b01000,
    S_SETTLE   = 5'b10000
  } rst_state_e;

  // NSSR write data that requests a subsystem reset ("NVMe" in ASCII).
  localparam logic [31:0] NSSR_MAGIC = 32'h4E564D65;

  // Default timing, in cpu_bus_clk cycles.
  localparam int unsigned DEF_REQ_HOLD    = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 64;
  localparam int unsigned DEF_SETTLE      = 16;
  localparam int unsigned DEF_RDY_DLY     = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 8;

  // Largest of four values; sizes the shared down-counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/nvme_user_rst_req.sv
// Purpose : turn NVMe controller reset events (CC.EN fall, NSSR magic write) into a
//           level-held user-logic reset request and track it to completion.
// Latency : request asserts 1 cycle after the trigger; all outputs are registered.
// Backpressure: none; triggers while busy are merged (NSSR) or dropped (CC.EN fall).
//
// Ports:
//   cpu_bus_clk / cpu_bus_rst   : clock, synchronous active-high reset
//   nvme_cc_en                  : CC.EN level from the register file
//   nssr_wr / nssr_wdata        : NSSR write strobe and data
//   nssro_clr                   : RW1C clear of CSTS.NSSRO
//   pcie_user_rst_n             : user reset returned by the PCIe sequencer (active-low)
//   pcie_user_logic_rst         : registered reset request to the sequencer
//   nvme_csts_rdy / nvme_csts_nssro : CSTS.RDY, CSTS.NSSRO (sticky)
//   rst_timeout                 : sticky, sequencer never acknowledged a request
//   rst_busy                    : any state other than IDLE
module nvme_user_rst_req
  import nvme_rst_pkg::*;
#(
  parameter int unsigned P_REQ_HOLD    = DEF_REQ_HOLD,
  parameter int unsigned P_ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned P_SETTLE      = DEF_SETTLE,
  parameter int unsigned P_RDY_DLY     = DEF_RDY_DLY,
  parameter int unsigned P_CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic        cpu_bus_clk,
  input  logic        cpu_bus_rst,
  input  logic        nvme_cc_en,
  input  logic        nssr_wr,
  input  logic [31:0] nssr_wdata,
  input  logic        nssro_clr,
  input  logic        pcie_user_rst_n,
  output logic        pcie_user_logic_rst,
  output logic        nvme_csts_rdy,
  output logic        nvme_csts_nssro,
  output logic        rst_timeout,
  output logic        rst_busy
);

  localparam int unsigned MAX_P = max4(P_REQ_HOLD, P_ACK_TIMEOUT, P_SETTLE, P_RDY_DLY);

  // The shared counter must hold every reload value, and every interval is at least
  // one cycle long (reload values are P-1).
  generate
    if ((MAX_P >> P_CNT_WIDTH) != 0) begin : g_bad_cnt_width
      $error("nvme_user_rst_req: P_CNT_WIDTH too small for the largest timing parameter");
    end
    if (P_REQ_HOLD == 0 || P_ACK_TIMEOUT == 0 || P_SETTLE == 0 || P_RDY_DLY == 0) begin : g_bad_zero
      $error("nvme_user_rst_req: timing parameters must be nonzero");
    end
  endgenerate

  typedef logic [P_CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t C_REQ    = cnt_t'(P_REQ_HOLD - 1);
  localparam cnt_t C_ACK    = cnt_t'(P_ACK_TIMEOUT - 1);
  localparam cnt_t C_SETTLE = cnt_t'(P_SETTLE - 1);
  localparam cnt_t C_RDY    = cnt_t'(P_RDY_DLY - 1);

  rst_state_e state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic       pending, pending_nxt;
  logic       ack_seen, ack_seen_nxt;
  logic       cc_en_d;

  logic       cc_fall, nssr_hit, trig, cnt_zero;
  logic       logic_rst_nxt, rdy_nxt, nssro_nxt, timeout_nxt;

  assign cc_fall  = cc_en_d & ~nvme_cc_en;
  assign nssr_hit = nssr_wr & (nssr_wdata == NSSR_MAGIC);
  assign trig     = cc_fall | nssr_hit;
  assign cnt_zero = (cnt == '0);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_bus_clk) begin
    if (cpu_bus_rst) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      pending             <= 1'b0;
      ack_seen            <= 1'b0;
      cc_en_d             <= 1'b0;
      pcie_user_logic_rst <= 1'b0;
      nvme_csts_rdy       <= 1'b0;
      nvme_csts_nssro     <= 1'b0;
      rst_timeout         <= 1'b0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      pending             <= pending_nxt;
      ack_seen            <= ack_seen_nxt;
      cc_en_d             <= nvme_cc_en;
      pcie_user_logic_rst <= logic_rst_nxt;
      nvme_csts_rdy       <= rdy_nxt;
      nvme_csts_nssro     <= nssro_nxt;
      rst_timeout         <= timeout_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counter and pending-request logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pending_nxt  = pending;
    ack_seen_nxt = ack_seen;

    // NSSR hits arriving mid-sequence collapse into a single follow-up request.
    if (nssr_hit && (state != S_IDLE)) pending_nxt = 1'b1;

    unique case (state)
      S_IDLE: begin
        if (trig) begin
          state_nxt    = S_REQ;
          cnt_nxt      = C_REQ;
          ack_seen_nxt = 1'b0;
        end else if (!nvme_cc_en) begin
          cnt_nxt = C_RDY;
        end else if (!cnt_zero) begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end

      S_REQ: begin
        // A fast sequencer may drop pcie_user_rst_n while we are still holding the
        // request; remember it so WAIT_ACK does not miss a short pulse.
        if (!pcie_user_rst_n) ack_seen_nxt = 1'b1;
        if (cnt_zero) begin
          state_nxt = S_WAIT_ACK;
          cnt_nxt   = C_ACK;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end

      S_WAIT_ACK: begin
        if (!pcie_user_rst_n || ack_seen) begin
          state_nxt = S_WAIT_REL;
        end else if (cnt_zero) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = C_SETTLE;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end

      // No bound here: a hot reset may keep pcie_user_rst_n low for a long time.
      S_WAIT_REL: begin
        if (pcie_user_rst_n) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = C_SETTLE;
        end
      end

      S_SETTLE: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - cnt_t'(1);
        end else if (pending) begin
          // Taking the pending request wins over a hit in this same cycle; that hit
          // is served by the request that is just starting.
          pending_nxt  = 1'b0;
          state_nxt    = S_REQ;
          cnt_nxt      = C_REQ;
          ack_seen_nxt = 1'b0;
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = C_RDY;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = C_RDY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered output values
  // ---------------------------------------------------------------------------
  always_comb begin
    logic_rst_nxt = (state_nxt == S_REQ);
    // RDY only sets after the counter has run out with CC.EN continuously high;
    // any CC.EN low or any trigger forces it back to 0.
    rdy_nxt       = (state == S_IDLE) && !trig && nvme_cc_en && cnt_zero;
    // Set wins over a simultaneous RW1C clear.
    nssro_nxt     = nssr_hit | (nvme_csts_nssro & ~nssro_clr);
    timeout_nxt   = rst_timeout |
                    ((state == S_WAIT_ACK) && pcie_user_rst_n && !ack_seen && cnt_zero);
  end

  assign rst_busy = (state != S_IDLE);

endmodule

// File: doc/nvme_user_rst_req.md
Name: nvme_user_rst_req

Overview:
- Upstream neighbour of the PCIe system-reset sequencer.
- Converts NVMe controller-level reset events into a registered, level-held `pcie_user_logic_rst` request: CC.EN falling edge, or an NSSR write of 0x4E564D65 ("NVMe").
- Tracks the resulting `pcie_user_rst_n` pulse from the sequencer to completion, then reports CSTS.RDY, CSTS.NSSRO and a timeout status to the register file.
- Lives entirely in the cpu_bus_clk domain.

Parameters:
- P_REQ_HOLD, 4: cycles `pcie_user_logic_rst` is held high per request.
- P_ACK_TIMEOUT, 64: max cycles to wait for `pcie_user_rst_n` to go low after the request starts.
- P_SETTLE, 16: cycles to wait after `pcie_user_rst_n` returns high before the block is idle again.
- P_RDY_DLY, 8: cycles CC.EN must be stable high in IDLE before CSTS.RDY sets.
- P_CNT_WIDTH, 8: width of the shared down-counter; must hold the maximum of the above values.

Ports:
- cpu_bus_clk, in, 1: single clock.
- cpu_bus_rst, in, 1: synchronous, active-high reset.
- nvme_cc_en, in, 1: CC.EN level from the register file.
- nssr_wr, in, 1: one-cycle NSSR register write strobe.
- nssr_wdata, in, 32: NSSR write data.
- nssro_clr, in, 1: one-cycle RW1C clear of NSSRO.
- pcie_user_rst_n, in, 1: user reset returned by the sequencer; active-low.
- pcie_user_logic_rst, out, 1: registered reset request to the sequencer.
- nvme_csts_rdy, out, 1: CSTS.RDY.
- nvme_csts_nssro, out, 1: CSTS.NSSRO, sticky.
- rst_timeout, out, 1: sticky; the sequencer never acknowledged a request.
- rst_busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset (`cpu_bus_rst`=1 on a clock edge):
  - All outputs go to 0, the state goes to IDLE, the counter and pending flag clear.
  - `cc_en_d` (registered copy of `nvme_cc_en`) loads 0.
  - A reset in the middle of any sequence aborts it immediately; `pcie_user_logic_rst` drops on the next edge.
- Trigger decode:
  - `cc_fall` = `cc_en_d` & ~`nvme_cc_en`.
  - `nssr_hit` = `nssr_wr` & (`nssr_wdata` == 32'h4E564D65). Any other data is ignored.
  - `trig` = `cc_fall` | `nssr_hit`.
  - `nssr_hit` sets `nvme_csts_nssro` on the next edge in every state.
  - `nssro_clr` clears NSSRO. If `nssro_clr` and `nssr_hit` occur in the same cycle, set wins.
- States (one-hot): IDLE, REQ, WAIT_ACK, WAIT_REL, SETTLE.
  - IDLE:
    - On `trig`: counter ← P_REQ_HOLD-1, go to REQ, `nvme_csts_rdy` ← 0 on the same edge.
    - Otherwise, if `nvme_cc_en`=1, the counter counts P_RDY_DLY cycles, then `nvme_csts_rdy` ← 1.
    - If `nvme_cc_en`=0, the counter reloads and RDY stays at 0.
  - REQ:
    - `pcie_user_logic_rst`=1 (registered, so high from cycle 1 after the trigger cycle) for exactly P_REQ_HOLD cycles.
    - At count 0: counter ← P_ACK_TIMEOUT-1, go to WAIT_ACK.
  - WAIT_ACK:
    - `pcie_user_rst_n`=0 → go to WAIT_REL. Sampling starts in REQ; a low seen during REQ is remembered and WAIT_ACK exits on its first cycle.
    - Counter reaches 0 with no low seen → `rst_timeout` ← 1, counter ← P_SETTLE-1, go to SETTLE.
  - WAIT_REL:
    - Waits with no bound for `pcie_user_rst_n`=1 (a hot reset can be long).
    - Then counter ← P_SETTLE-1, go to SETTLE.
  - SETTLE:
    - Count down to 0.
    - If the pending flag is set: clear it and go directly to REQ (counter ← P_REQ_HOLD-1).
    - Otherwise go to IDLE with the RDY counter reloaded.
- Triggers while busy:
  - `nssr_hit` in any non-IDLE state sets the pending flag; multiple hits merge into one pending request.
  - `cc_fall` while busy is ignored; the reset is already in progress.
- CSTS.RDY:
  - Held at 0 in every non-IDLE state.
  - Clears in the cycle after `nvme_cc_en` falls, even when `trig` is masked.
- Counter:
  - Unsigned; it only decrements while nonzero, so there is no wrap-around.
  - Width is checked at elaboration: the maximum parameter value must be less than 2^P_CNT_WIDTH.
- `rst_timeout` clears only on `cpu_bus_rst`.

Decomposition:
- Shared package nvme_rst_pkg holds:
  - the state encodings S_IDLE..S_SETTLE;
  - the NSSR magic constant 32'h4E564D65;
  - the default P_* values.
- No sub-module. The single down-counter and the FSM stay inline.

Test Plan:
- CC.EN 0→1 held → `nvme_csts_rdy`=1 exactly 8 cycles later. Then CC.EN 1→0 → RDY=0 next cycle; `pcie_user_logic_rst` high cycles 1–4; `rst_busy` high until the sequencer completes and 16 SETTLE cycles elapse.
- NSSR write 0x4E564D65 with `pcie_user_rst_n` pulsed low for 50 cycles → NSSRO=1, one 4-cycle request, IDLE 16 cycles after release. NSSR write 0x12345678 → no response.
- `pcie_user_rst_n` held high throughout → `rst_timeout`=1 at cycle 4+64 after the trigger, then SETTLE, then IDLE; `rst_timeout` stays 1 until `cpu_bus_rst`.
- Two NSSR hits during WAIT_REL → exactly one additional request after SETTLE, with no IDLE cycle in between.
- `nssro_clr` and `nssr_hit` in the same cycle → NSSRO remains 1. `nssro_clr` alone → NSSRO=0.
- `cpu_bus_rst` asserted during REQ cycle 2 → `pcie_user_logic_rst`=0 on the next edge, all outputs 0, state IDLE.
